// File: rtl/tt_um_xor_spi_decrypt.sv
// SPI mode-0 (MSB first) serial receiver that XOR-decrypts each byte with KEY.
// Latency: plaintext and valid pulse appear SYNC_STAGES+1 clk after the physical 8th SCLK rise.
// Backpressure: none; the byte_valid pulse is one cycle wide and the data is held until the next byte.
module tt_um_xor_spi_decrypt #(
   parameter logic [7:0] KEY         = 8'hBE,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Synchronizer chains, all of equal depth so SCLK and MOSI stay aligned.
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_csn_sync;
   // Marks when the chains hold real post-reset samples rather than reset values.
   logic [SYNC_STAGES-1:0] r_fill;
   logic                   r_sclk_prev;
   // Set once CS_N has genuinely been seen high; a frame may only start when armed.
   logic                   r_cs_armed;

   logic                   w_sclk_s;
   logic                   w_mosi_s;
   logic                   w_csn_s;
   logic                   w_sclk_rise;
   logic                   w_fill_done;
   logic                   w_start;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [7:0]             r_shift;
   logic [7:0]             w_shift_nxt;
   logic [2:0]             r_bit_cnt;
   logic [2:0]             w_bit_cnt_nxt;
   logic [5:0]             r_byte_cnt;
   logic [5:0]             w_byte_cnt_nxt;
   logic [7:0]             r_data;
   logic [7:0]             w_data_nxt;
   logic                   r_valid;
   logic                   w_valid_nxt;
   logic [7:0]             w_shift_in;

   // Inputs that have no function in this design.
   logic                   w_unused;
   assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
   assign w_fill_done = r_fill[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
   assign w_shift_in  = {r_shift[6:0], w_mosi_s};

   // A frame starts only after CS_N was observed high, so a frame already in
   // progress when reset is released is ignored until CS_N goes high then low.
   assign w_start = (r_state == ST_IDLE) && r_cs_armed && !w_csn_s;

   // Input synchronizers, SCLK edge history and the frame-start arming flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_csn_sync  <= '1;
         r_fill      <= '0;
         r_sclk_prev <= 1'b0;
         r_cs_armed  <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], ui_in[0]};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], ui_in[1]};
         r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], ui_in[2]};
         r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
         r_sclk_prev <= w_sclk_s;
         if (w_start) begin
            r_cs_armed <= 1'b0;
         end else if (w_fill_done && w_csn_s) begin
            r_cs_armed <= 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath next values: shift on SCLK rise, complete a byte on the
   // 8th bit, and leave the frame when CS_N is high (after completing a same-cycle byte).
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_byte_cnt_nxt = r_byte_cnt;
      w_data_nxt     = r_data;
      w_valid_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt    = ST_SHIFT;
               w_shift_nxt    = 8'h00;
               w_bit_cnt_nxt  = 3'd0;
               w_byte_cnt_nxt = 6'd0;
            end
         end
         ST_SHIFT: begin
            if (w_sclk_rise) begin
               w_shift_nxt = w_shift_in;
               if (r_bit_cnt == 3'd7) begin
                  w_data_nxt     = w_shift_in ^ KEY;
                  w_valid_nxt    = 1'b1;
                  w_byte_cnt_nxt = r_byte_cnt + 6'd1;
                  w_bit_cnt_nxt  = 3'd0;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end
            if (w_csn_s) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Datapath registers; partial bytes are simply dropped at frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift    <= 8'h00;
         r_bit_cnt  <= 3'd0;
         r_byte_cnt <= 6'd0;
         r_data     <= 8'h00;
         r_valid    <= 1'b0;
      end else begin
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
      end
   end

   assign uo_out  = r_data;
   assign uio_out = {r_byte_cnt, (r_state == ST_SHIFT), r_valid};
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_xor_spi_decrypt.sv
// Scoreboard bench for the XOR SPI decryptor: stimulus pushes expected bytes,
// a monitor pops and compares on every byte_valid pulse.
// Directed checks cover reset, frame_active, count hold, abort and reset mid-byte.
`timescale 1ns/1ps
module tb_tt_um_xor_spi_decrypt;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   wire  [7:0] uo_out;
   wire  [7:0] uio_out;
   wire  [7:0] uio_oe;

   tt_um_xor_spi_decrypt dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [13:0] exp_q[$];
   logic [13:0] mon_e;
   logic [5:0]  exp_cnt = 6'd0;
   int          since_rise = 100;
   logic        tb_sclk = 1'b0;
   logic        tb_mosi = 1'b0;
   logic        tb_csn = 1'b1;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Unused upper bits get fresh random values on every update.
   task automatic drive();
      ui_in = {5'($urandom), tb_csn, tb_mosi, tb_sclk};
   endtask

   // Sends the top nbits of cipher MSB first, SCLK = clk/8. Only a full byte
   // produces an expected scoreboard entry.
   task automatic send_bits(input logic [7:0] cipher, input logic [7:0] plain, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         tb_sclk = 1'b0;
         tb_mosi = cipher[i];
         drive();
         repeat (4) @(negedge clk);
         tb_sclk = 1'b1;
         drive();
         if (i == 0) begin
            exp_cnt++;
            exp_q.push_back({plain, exp_cnt});
            since_rise = 0;
         end
         repeat (4) @(negedge clk);
      end
      tb_sclk = 1'b0;
      drive();
   endtask

   task automatic start_frame();
      tb_csn = 1'b0;
      drive();
      repeat (4) @(negedge clk);
      exp_cnt = 6'd0;
      chk("frame_active_on", {7'd0, uio_out[1]}, 8'd1);
      chk("count_cleared", {2'd0, uio_out[7:2]}, 8'd0);
   endtask

   task automatic end_frame(input logic [7:0] hold);
      tb_csn = 1'b1;
      drive();
      repeat (4) @(negedge clk);
      chk("frame_active_off", {7'd0, uio_out[1]}, 8'd0);
      chk("count_hold", {2'd0, uio_out[7:2]}, {2'd0, exp_cnt});
      chk("uo_out_hold", uo_out, hold);
   endtask

   // Monitor: every byte_valid pulse must match the oldest expected entry,
   // arriving 3 clk edges after the 8th SCLK rise was driven.
   initial begin
      forever begin
         @(posedge clk);
         since_rise++;
         #1;
         if (uio_out[0] === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pulse: uo_out %02h count %0d, none expected at %0t",
                        uo_out, uio_out[7:2], $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("plaintext", uo_out, mon_e[13:6]);
               chk("byte_count", {2'd0, uio_out[7:2]}, {2'd0, mon_e[5:0]});
               chk("latency", 8'(since_rise), 8'd3);
            end
         end
      end
   end

   initial begin
      uio_in = 8'($urandom);
      rst_n  = 1'b0;
      repeat (3) begin
         ui_in = 8'($urandom);
         @(negedge clk);
      end
      chk("reset_uo_out", uo_out, 8'h00);
      chk("reset_uio_out", uio_out, 8'h00);
      chk("reset_uio_oe", uio_oe, 8'hFF);
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("idle_uo_out", uo_out, 8'h00);
      chk("idle_uio_out", uio_out, 8'h00);
      chk("idle_uio_oe", uio_oe, 8'hFF);

      // Single byte: 0x1F ^ 0xBE = 0xA1
      start_frame();
      send_bits(8'h1F, 8'hA1, 8);
      end_frame(8'hA1);

      // Key identity and multi-byte frame
      start_frame();
      send_bits(8'hBE, 8'h00, 8);
      send_bits(8'h00, 8'hBE, 8);
      send_bits(8'hFF, 8'h41, 8);
      end_frame(8'h41);

      // Abort after 5 bits, then a clean byte
      start_frame();
      send_bits(8'hFF, 8'h00, 5);
      end_frame(8'h41);
      start_frame();
      send_bits(8'h00, 8'hBE, 8);
      end_frame(8'hBE);

      // Count wrap: 65 bytes of 0x55 -> 0xEB, count 63, 0, 1
      start_frame();
      repeat (65) send_bits(8'h55, 8'hEB, 8);
      end_frame(8'hEB);

      // Reset mid-byte with CS_N still low afterwards
      start_frame();
      send_bits(8'hF0, 8'h00, 4);
      rst_n = 1'b0;
      #1;
      chk("async_reset_uo_out", uo_out, 8'h00);
      chk("async_reset_uio_out", uio_out, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("stale_frame_ignored", {7'd0, uio_out[1]}, 8'd0);
      exp_cnt = 6'd0;
      send_bits(8'hA5, 8'h00, 4);
      end_frame(8'h00);
      start_frame();
      send_bits(8'h3C, 8'h82, 8);
      end_frame(8'h82);

      repeat (10) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL missing_pulses: %0d expected bytes never presented, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
